// File: rtl/instruction_cache.sv
// Direct-mapped instruction cache: NUM_SETS blocks of 16 bytes, read-only,
// zero-latency hits, block fill from a multi-beat instruction memory.
module instruction_cache #(
    parameter int NUM_SETS = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         read,
    input  logic [31:0]  address,
    output logic [31:0]  readdata,
    output logic         busywait,
    output logic         mem_read,
    output logic [27:0]  mem_address,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait
);

    localparam int IDX   = $clog2(NUM_SETS);
    localparam int TAG_W = 28 - IDX;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_next_s;

    logic [NUM_SETS-1:0]  valid_r;
    logic [TAG_W-1:0]     tag_r  [NUM_SETS];
    logic [127:0]         data_r [NUM_SETS];

    logic [IDX-1:0]       index_s;
    logic [TAG_W-1:0]     tag_s;
    logic [1:0]           word_s;
    logic [127:0]         block_s;
    logic                 hit_s;
    logic                 fill_s;
    logic                 unused_s;

    assign index_s     = address[4 +: IDX];
    assign tag_s       = address[31:4+IDX];
    assign word_s      = address[3:2];
    assign block_s     = data_r[index_s];
    assign hit_s       = valid_r[index_s] && (tag_r[index_s] == tag_s);
    // The block is captured only in UPDATE: the final byte from memory lands
    // on the edge that leaves MEM_READ, so it is not stable until then.
    assign fill_s      = (state_r == UPDATE);
    assign mem_address = address[31:4];
    assign unused_s    = ^address[1:0];

    // FSM state register; reset aborts any fill in progress immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Valid bits: cleared on reset, set for the indexed set when a fill completes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_r <= {NUM_SETS{1'b0}};
        end else if (fill_s) begin
            valid_r[index_s] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag and data storage; a fill simply overwrites the set (no write-back).
    always_ff @(posedge clock) begin
        if (fill_s) begin
            tag_r[index_s]  <= tag_s;
            data_r[index_s] <= mem_readdata;
        end
    end

    // Next-state and handshake outputs; busywait stays high for the whole fill
    // even if the CPU drops read, so the fill always completes.
    always_comb begin
        state_next_s = state_r;
        busywait     = 1'b0;
        mem_read     = 1'b0;
        case (state_r)
            IDLE: begin
                if (read && !hit_s) begin
                    busywait     = 1'b1;
                    state_next_s = MEM_READ;
                end else begin
                    busywait     = 1'b0;
                    state_next_s = IDLE;
                end
            end
            MEM_READ: begin
                mem_read = 1'b1;
                busywait = 1'b1;
                if (!mem_busywait) begin
                    state_next_s = UPDATE;
                end else begin
                    state_next_s = MEM_READ;
                end
            end
            UPDATE: begin
                busywait     = 1'b1;
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Word select within the indexed block.
    always_comb begin
        readdata = 32'd0;
        case (word_s)
            2'd0:    readdata = block_s[31:0];
            2'd1:    readdata = block_s[63:32];
            2'd2:    readdata = block_s[95:64];
            2'd3:    readdata = block_s[127:96];
            default: readdata = 32'd0;
        endcase
    end

endmodule
